bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter for the calculator datapath. It takes an unsigned binary result (for example the quotient from the divider) and produces the hundreds, tens and ones BCD digits consumed by the seven-segment display decoders. It uses shift-and-add-3 (double dabble) iteration, one bit per clock, behind a start/busy/done handshake. Out-of-range and blanked digits are driven as 4'hF, which the display decoders render as an unlit digit.

---
 rtl/calc_pkg.sv | 19 +
 rtl/bcd_add3.sv | 15 +
 rtl/bin2bcd_seq.sv | 132 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator display datapath.
//   state_e     : controller states of the sequential BCD converter
//   bcd_t       : one BCD digit (4 bits)
//   BLANK_DIGIT : code the seven-segment decoders render as an unlit digit
//   BCD_MAX     : largest value representable in three BCD digits
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t        BLANK_DIGIT = 4'hF;
  localparam int unsigned BCD_MAX     = 999;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
// Ports:
//   dig_i : BCD digit before correction
//   dig_o : corrected digit
module bcd_add3
  import calc_pkg::*;
(
  input  bcd_t dig_i,
  output bcd_t dig_o
);

  assign dig_o = (dig_i >= 4'd5) ? dig_i + 4'd3 : dig_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Parameters:
//   WIDTH    : binary input width, 4..10
//   BLANK_LZ : 1 = show leading-zero hundreds/tens digits as BLANK_DIGIT
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : conversion request, sampled only while idle
//   bin   : unsigned value, captured on the accepting edge
//   busy  : conversion in progress (start ignored)
//   done  : one-cycle pulse, digits valid in the same cycle
//   ovf   : last result exceeded 999
//   hun/ten/one : BCD digits or BLANK_DIGIT, held until the next result
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       hun,
  output logic [3:0]       ten,
  output logic [3:0]       one
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_pend_q;

  logic [WIDTH-1:0] shreg_q;
  logic [11:0]      scratch_q;
  logic [WIDTH-1:0] shreg_d;
  logic [11:0]      scratch_d;

  bcd_t adj_h, adj_t, adj_o;
  logic unused_carry;

  // Digit formatting for the display: overflow blanks everything; optional
  // leading-zero blanking never touches the ones digit, and an inner zero
  // (e.g. the tens of 305) is kept because hundreds is non-zero.
  function automatic logic [11:0] format_digits(input logic [11:0] s,
                                                input logic        of);
    bcd_t h, t, o;
    h = s[11:8];
    t = s[7:4];
    o = s[3:0];
    if (of) begin
      h = BLANK_DIGIT;
      t = BLANK_DIGIT;
      o = BLANK_DIGIT;
    end else if (BLANK_LZ) begin
      if (h == 4'd0) begin
        h = BLANK_DIGIT;
        if (t == 4'd0) t = BLANK_DIGIT;
      end
    end
    return {h, t, o};
  endfunction

  bcd_add3 u_add3_hun (.dig_i(scratch_q[11:8]), .dig_o(adj_h));
  bcd_add3 u_add3_ten (.dig_i(scratch_q[7:4]),  .dig_o(adj_t));
  bcd_add3 u_add3_one (.dig_i(scratch_q[3:0]),  .dig_o(adj_o));

  // The hundreds carry-out is only ever set for inputs above 999, whose
  // scratch contents are discarded in favour of ovf.
  assign unused_carry = adj_h[3];

  always_comb begin
    scratch_d = {adj_h[2:0], adj_t, adj_o, shreg_q[WIDTH-1]};
    shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
  end

  assign busy = (state_q != IDLE);

  // Datapath: shift register and BCD scratch carry no reset; they are
  // reloaded on every accepted request.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      shreg_q   <= bin;
      scratch_q <= '0;
    end else if (state_q == SHIFT) begin
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
    end
  end

  // Controller with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      hun        <= BLANK_DIGIT;
      ten        <= BLANK_DIGIT;
      one        <= BLANK_DIGIT;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q      <= '0;
            ovf_pend_q <= (32'(bin) > BCD_MAX);
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= DONE;
        end
        DONE: begin
          {hun, ten, one} <= format_digits(scratch_q, ovf_pend_q);
          ovf             <= ovf_pend_q;
          done            <= 1'b1;
          state_q         <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: one instance without and one with
// leading-zero blanking, driven by the same start/bin stimulus.
module tb_bin2bcd_seq;

  localparam int W = 10;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] bin   = '0;

  logic       busy0, done0, ovf0;
  logic [3:0] hun0, ten0, one0;
  logic       busy1, done1, ovf1;
  logic [3:0] hun1, ten1, one1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(W), .BLANK_LZ(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy0), .done(done0), .ovf(ovf0),
    .hun(hun0), .ten(ten0), .one(one0)
  );

  bin2bcd_seq #(.WIDTH(W), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy1), .done(done1), .ovf(ovf1),
    .hun(hun1), .ten(ten1), .one(one1)
  );

  // One request: start for one cycle (accepting edge E0), then observe
  // W+4 further edges. lat = edge index of the first done pulse.
  task automatic run_conv(input logic [W-1:0] v, output int lat,
                          output int busy_cyc, output int done_cyc,
                          output logic [11:0] mid, output logic overlap);
    lat = -1; busy_cyc = 0; done_cyc = 0; overlap = 1'b0; mid = '0;
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bin   = ~v;
    if (busy0) busy_cyc++;
    for (int k = 1; k <= W + 4; k++) begin
      @(posedge clk); #1;
      if (busy0) busy_cyc++;
      if (done0) begin
        done_cyc++;
        if (lat < 0) lat = k;
      end
      if ((busy0 && done0) || (busy1 && done1)) overlap = 1'b1;
      if (k == 5) mid = {hun0, ten0, one0};
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({busy0, done0, ovf0} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/done/ovf got %b expected 000", {busy0, done0, ovf0});
    end
    n_chk++;
    if ({hun0, ten0, one0, hun1, ten1, one1} !== 24'hFFF_FFF) begin
      n_fail++;
      $display("FAIL reset_digits: got %h/%h expected FFF/FFF",
               {hun0, ten0, one0}, {hun1, ten1, one1});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    int lat, bc, dc;
    logic [11:0] mid;
    logic ov;
    run_conv('0, lat, bc, dc, mid, ov);
    n_chk++;
    if (lat !== W + 1) begin
      n_fail++;
      $display("FAIL zero_latency: got %0d expected %0d", lat, W + 1);
    end
    n_chk++;
    if (mid !== 12'hFFF) begin
      n_fail++;
      $display("FAIL zero_pre_done_digits: got %h expected FFF", mid);
    end
    n_chk++;
    if ({ovf0, hun0, ten0, one0} !== {1'b0, 12'h000}) begin
      n_fail++;
      $display("FAIL zero_result: got ovf=%b %h expected ovf=0 000", ovf0, {hun0, ten0, one0});
    end
  endtask

  task automatic test_handshake();
    int lat, bc, dc;
    logic [11:0] mid;
    logic ov;
    run_conv(10'd255, lat, bc, dc, mid, ov);
    n_chk++;
    if (bc !== W + 1) begin
      n_fail++;
      $display("FAIL hs_busy_cycles: got %0d expected %0d", bc, W + 1);
    end
    n_chk++;
    if (dc !== 1) begin
      n_fail++;
      $display("FAIL hs_done_cycles: got %0d expected 1", dc);
    end
    n_chk++;
    if (ov !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_busy_done_overlap: got %b expected 0", ov);
    end
    n_chk++;
    if ({hun0, ten0, one0} !== 12'h255) begin
      n_fail++;
      $display("FAIL hs_result_255: got %h expected 255", {hun0, ten0, one0});
    end
  endtask

  task automatic test_range();
    logic [W-1:0] vals [3] = '{10'd999, 10'd1000, 10'd1023};
    logic [11:0]  exps [3] = '{12'h999, 12'hFFF, 12'hFFF};
    logic         eovf [3] = '{1'b0, 1'b1, 1'b1};
    int lat, bc, dc;
    logic [11:0] mid;
    logic ov;
    for (int i = 0; i < 3; i++) begin
      run_conv(vals[i], lat, bc, dc, mid, ov);
      n_chk++;
      if ({ovf0, hun0, ten0, one0} !== {eovf[i], exps[i]}) begin
        n_fail++;
        $display("FAIL range_%0d: got ovf=%b %h expected ovf=%b %h",
                 vals[i], ovf0, {hun0, ten0, one0}, eovf[i], exps[i]);
      end
      n_chk++;
      if ({ovf1, hun1, ten1, one1} !== {eovf[i], exps[i]}) begin
        n_fail++;
        $display("FAIL range_blank_%0d: got ovf=%b %h expected ovf=%b %h",
                 vals[i], ovf1, {hun1, ten1, one1}, eovf[i], exps[i]);
      end
    end
  endtask

  task automatic test_blank();
    logic [W-1:0] vals  [4] = '{10'd7, 10'd40, 10'd305, 10'd0};
    logic [11:0]  exp_b [4] = '{12'hFF7, 12'hF40, 12'h305, 12'hFF0};
    logic [11:0]  exp_p [4] = '{12'h007, 12'h040, 12'h305, 12'h000};
    int lat, bc, dc;
    logic [11:0] mid;
    logic ov;
    for (int i = 0; i < 4; i++) begin
      run_conv(vals[i], lat, bc, dc, mid, ov);
      n_chk++;
      if ({hun1, ten1, one1} !== exp_b[i]) begin
        n_fail++;
        $display("FAIL blank_%0d: got %h expected %h", vals[i], {hun1, ten1, one1}, exp_b[i]);
      end
      n_chk++;
      if ({hun0, ten0, one0} !== exp_p[i]) begin
        n_fail++;
        $display("FAIL noblank_%0d: got %h expected %h", vals[i], {hun0, ten0, one0}, exp_p[i]);
      end
    end
  endtask

  // start held high while bin alternates a/b every cycle; with a period of
  // W+2 = 12 (even) every accepting edge sees a, at E0, E12, E24.
  task automatic test_back_to_back(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [11:0] exp_a);
    int dones = 0;
    @(negedge clk);
    start = 1'b1;
    bin   = a;
    for (int k = 0; k <= 35; k++) begin
      @(posedge clk); #1;
      if (done0) begin
        dones++;
        n_chk++;
        if (!(k == 11 || k == 23 || k == 35)) begin
          n_fail++;
          $display("FAIL b2b_done_edge_%0d: done at E%0d expected E11/E23/E35", a, k);
        end
        n_chk++;
        if ({hun0, ten0, one0} !== exp_a) begin
          n_fail++;
          $display("FAIL b2b_result_%0d: got %h expected %h at E%0d", a, {hun0, ten0, one0}, exp_a, k);
        end
      end
      @(negedge clk);
      bin = ((k + 1) % 2 == 0) ? a : b;
    end
    start = 1'b0;
    n_chk++;
    if (dones !== 3) begin
      n_fail++;
      $display("FAIL b2b_done_count_%0d: got %0d expected 3", a, dones);
    end
    repeat (W + 4) @(posedge clk);
  endtask

  task automatic test_abort();
    int lat, bc, dc;
    logic [11:0] mid;
    logic ov;
    logic seen_done = 1'b0;
    @(negedge clk);
    bin   = 10'd678;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({busy0, done0, ovf0} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_ctrl: busy/done/ovf got %b expected 000", {busy0, done0, ovf0});
    end
    n_chk++;
    if ({hun0, ten0, one0} !== 12'hFFF) begin
      n_fail++;
      $display("FAIL abort_digits: got %h expected FFF", {hun0, ten0, one0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge clk); #1;
      if (done0 || busy0) seen_done = 1'b1;
    end
    n_chk++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: activity after abort got %b expected 0", seen_done);
    end
    run_conv(10'd42, lat, bc, dc, mid, ov);
    n_chk++;
    if (lat !== W + 1) begin
      n_fail++;
      $display("FAIL abort_restart_latency: got %0d expected %0d", lat, W + 1);
    end
    n_chk++;
    if ({hun0, ten0, one0} !== 12'h042) begin
      n_fail++;
      $display("FAIL abort_restart_42: got %h expected 042", {hun0, ten0, one0});
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_handshake();
    test_range();
    test_blank();
    test_back_to_back(10'd12, 10'd345, 12'h012);
    test_back_to_back(10'd345, 10'd12, 12'h345);
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
